// File: rtl/exec_wb_if.sv
// Bundle of the issue, register-read, ALU and write-back signals around exec_wb_stage.
// The slave modport is the stage's view and the master modport is the surrounding datapath's view.
interface exec_wb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    // Issue handshake: an instruction transfers on a rising edge where issue_valid
    // and issue_ready are both high. The decoder holds its fields stable while
    // valid is high. issue_ready does not depend on issue_valid.
    logic              issue_valid;
    logic              issue_ready;
    logic [2:0]        issue_op;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] issue_rs1;
    logic [ADDR_W-1:0] issue_rs2;
    logic              kill;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ins;
    logic [DATA_W-1:0] alu_out;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              done;
    logic              zero_flag;
    logic              div_zero;

    modport slave (
        input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, kill,
        input  rs1_data, rs2_data, alu_out,
        output issue_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_ins,
        output wb_en, wb_addr, wb_data, done, zero_flag, div_zero
    );

    modport master (
        output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, kill,
        output rs1_data, rs2_data, alu_out,
        input  issue_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_ins,
        input  wb_en, wb_addr, wb_data, done, zero_flag, div_zero
    );
endinterface

// File: rtl/exec_wb_stage.sv
// Non-pipelined execute/write-back controller: it reads the operands, drives the
// external 8-bit ALU and writes one result to the register file per instruction.
module exec_wb_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    exec_wb_if.slave   bus,
    output logic [1:0] o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_OPER, S_EXEC, S_WB} state_t;

    localparam logic [2:0] OP_DIV = 3'b111;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic [DATA_W-1:0] w_result;
    logic              w_dz;

    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [2:0]        r_alu_ins;
    logic              r_dz;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_zero;
    logic              r_div_zero;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                // kill has no effect here, so an issue in the same cycle still lands
                if (bus.issue_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_OPER;
                end
            end
            S_OPER:  w_next = bus.kill ? S_IDLE : S_EXEC;
            S_EXEC:  w_next = bus.kill ? S_IDLE : S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A divide by zero bypasses the ALU and writes all-ones
    always_comb begin
        w_dz     = (r_alu_ins == OP_DIV) && (r_opb == '0);
        w_result = w_dz ? {DATA_W{1'b1}} : bus.alu_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_alu_ins  <= '0;
            r_dz       <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= bus.issue_op;
                r_rd  <= bus.issue_rd;
                r_rs1 <= bus.issue_rs1;
                r_rs2 <= bus.issue_rs2;
            end
            if (r_state == S_OPER && !bus.kill) begin
                r_opa     <= bus.rs1_data;
                r_opb     <= bus.rs2_data;
                r_alu_ins <= r_op;
            end
            if (r_state == S_EXEC && !bus.kill) begin
                r_wb_data <= w_result;
                r_wb_addr <= r_rd;
                r_dz      <= w_dz;
            end
            if (r_state == S_WB) begin
                r_zero     <= (r_wb_data == '0);
                r_div_zero <= r_dz;
            end
        end
    end

    // Every output is a register or a state decode, so each holds its value outside its own phase
    assign bus.issue_ready = (r_state == S_IDLE);
    assign bus.rs1_addr    = r_rs1;
    assign bus.rs2_addr    = r_rs2;
    assign bus.alu_a       = r_opa;
    assign bus.alu_b       = r_opb;
    assign bus.alu_ins     = r_alu_ins;
    assign bus.wb_en       = (r_state == S_WB);
    assign bus.done        = (r_state == S_WB);
    assign bus.wb_addr     = r_wb_addr;
    assign bus.wb_data     = r_wb_data;
    assign bus.zero_flag   = r_zero;
    assign bus.div_zero    = r_div_zero;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed bench for exec_wb_stage with a behavioural register file and ALU.
// It checks each instruction phase by phase, and also kill, back-pressure and asynchronous reset.
module tb_exec_wb_stage;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [7:0] regs [16];
    int         n_vec;
    int         n_err;

    exec_wb_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    exec_wb_stage #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rs1_data = regs[bus.rs1_addr];
    assign bus.rs2_data = regs[bus.rs2_addr];

    always_comb begin
        bus.alu_out = 8'h00;
        case (bus.alu_ins)
            3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
            3'b010:  bus.alu_out = bus.alu_a & bus.alu_b;
            3'b011:  bus.alu_out = bus.alu_a | bus.alu_b;
            3'b100:  bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b101:  bus.alu_out = ~bus.alu_a;
            3'b110:  bus.alu_out = bus.alu_a * bus.alu_b;
            default: bus.alu_out = (bus.alu_b == 8'h00) ? 8'h00 : bus.alu_a / bus.alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_issue(input logic [2:0] op, input logic [3:0] rd,
                               input logic [3:0] rs1, input logic [3:0] rs2);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_rd    = rd;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
    endtask

    // Called at a falling edge while the stage is idle; returns at the falling edge of cycle 4
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [3:0] rd,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d,
                             input logic exp_z, input logic exp_dz);
        drive_issue(op, rd, 4'd3, 4'd5);
        check({tag, "_ready_c0"}, bus.issue_ready, 1);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        check({tag, "_ready_c1"}, bus.issue_ready, 0);
        check({tag, "_rs1_addr"}, bus.rs1_addr, 3);
        check({tag, "_rs2_addr"}, bus.rs2_addr, 5);
        @(negedge clk);
        check({tag, "_alu_a"}, bus.alu_a, a);
        check({tag, "_alu_b"}, bus.alu_b, b);
        check({tag, "_alu_ins"}, bus.alu_ins, op);
        check({tag, "_wb_en_c2"}, bus.wb_en, 0);
        @(negedge clk);
        check({tag, "_wb_en_c3"}, bus.wb_en, 1);
        check({tag, "_done_c3"}, bus.done, 1);
        check({tag, "_wb_addr"}, bus.wb_addr, rd);
        check({tag, "_wb_data"}, bus.wb_data, exp_d);
        @(negedge clk);
        check({tag, "_wb_en_c4"}, bus.wb_en, 0);
        check({tag, "_ready_c4"}, bus.issue_ready, 1);
        check({tag, "_zero_flag"}, bus.zero_flag, exp_z);
        check({tag, "_div_zero"}, bus.div_zero, exp_dz);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        rst_n           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_op    = 3'b000;
        bus.issue_rd    = 4'd0;
        bus.issue_rs1   = 4'd0;
        bus.issue_rs2   = 4'd0;
        bus.kill        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.issue_ready, 1);
        check("rst_wb_en", bus.wb_en, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        regs[3] = 8'd20; regs[5] = 8'd7;
        run_instr("add", 3'b000, 4'd1, 8'd20, 8'd7, 8'd27, 1'b0, 1'b0);
        regs[3] = 8'd5;
        run_instr("sub", 3'b001, 4'd1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0);
        regs[3] = 8'h20; regs[5] = 8'h10;
        run_instr("mul", 3'b110, 4'd0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0);

        // kill in EXEC: no write, idle next cycle, flags left as the mul set them
        drive_issue(3'b000, 4'd6, 4'd3, 4'd5);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("killx_state_exec", dbg_state, 2);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("killx_wb_en", bus.wb_en, 0);
        check("killx_ready", bus.issue_ready, 1);
        check("killx_zero_kept", bus.zero_flag, 1);
        repeat (2) begin
            @(negedge clk);
            check("killx_no_wb", bus.wb_en, 0);
        end

        regs[3] = 8'd9; regs[5] = 8'd0;
        run_instr("div0", 3'b111, 4'd2, 8'd9, 8'd0, 8'hFF, 1'b0, 1'b1);
        regs[5] = 8'd2;
        run_instr("div", 3'b111, 4'd2, 8'd9, 8'd2, 8'd4, 1'b0, 1'b0);

        // issue_valid held high across three back-to-back instructions
        regs[3] = 8'd20; regs[5] = 8'd7;
        drive_issue(3'b000, 4'd4, 4'd3, 4'd5);
        for (int i = 0; i < 12; i++) begin
            if (i == 9) bus.issue_valid = 1'b0;
            check($sformatf("b2b_ready_%0d", i), bus.issue_ready, (i % 4 == 0) ? 1 : 0);
            check($sformatf("b2b_wb_en_%0d", i), bus.wb_en, (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 3) check($sformatf("b2b_data_%0d", i), bus.wb_data, 27);
            @(negedge clk);
        end
        check("b2b_idle", bus.issue_ready, 1);

        // kill in WB is ignored; kill in IDLE still lets the issue in
        regs[3] = 8'h0F; regs[5] = 8'h3C;
        drive_issue(3'b100, 4'd7, 4'd3, 4'd5);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        bus.issue_valid = 1'b0;
        check("killi_state_oper", dbg_state, 1);
        @(negedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        check("killw_wb_en", bus.wb_en, 1);
        check("killw_wb_addr", bus.wb_addr, 7);
        check("killw_wb_data", bus.wb_data, 8'h33);
        @(negedge clk);
        bus.kill = 1'b0;
        check("killw_ready", bus.issue_ready, 1);
        check("killw_zero", bus.zero_flag, 0);

        // asynchronous reset in the middle of EXEC
        drive_issue(3'b000, 4'd8, 4'd3, 4'd5);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", bus.issue_ready, 1);
        check("arst_state", dbg_state, 0);
        check("arst_alu_a", bus.alu_a, 0);
        check("arst_rs1_addr", bus.rs1_addr, 0);
        check("arst_wb_data", bus.wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arst_no_wb_%0d", i), bus.wb_en, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
